// File: rtl/vga_mem_arbiter.sv
// Purpose: shares one single-port pixel memory between scan-out reads and a 1-entry buffered writer.
// Latency: scan read data 3 cycles after SCAN_REQ; memory port outputs 1 cycle after each grant decision.
// Backpressure: scan has none (always wins, or is dropped and flagged); writer is throttled by registered WR_RDY.
//
// Build option: define STARVE_GUARD_EN to let a held write preempt scan after WAIT_LIMIT blocked cycles;
// without it scan always wins, there is no wait counter and SCAN_MISS is tied low.
//
// Ports:
//   CLK, RST_N                       clock (rising edge) and synchronous active-low reset
//   SCAN_REQ, SCAN_ADDR              scan-out read request, one word per asserted cycle
//   SCAN_RVALID, SCAN_RDATA          read data, fixed 3-cycle latency
//   SCAN_MISS                        pulse at the slot where a preempted scan read's data would have been
//   WR_VALID, WR_ADDR, WR_DATA, WR_RDY  writer valid/ready handshake
//   MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_RDATA  single-port memory (read data 1 cycle after enable)
module vga_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int WAIT_LIMIT = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SCAN_REQ,
    input  logic [ADDR_W-1:0] SCAN_ADDR,
    output logic              SCAN_RVALID,
    output logic [DATA_W-1:0] SCAN_RDATA,
    output logic              SCAN_MISS,
    input  logic              WR_VALID,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_RDY,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_q, state_nxt;

    logic              wr_rdy_q;
    logic              wr_xfer;
    logic              wr_gnt;
    logic              scan_gnt;
    logic              starve;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;

    // Read pipeline valid bits: rd_p1 = address on the memory port, rd_p2 = MEM_RDATA valid.
    logic rd_p1_q, rd_p2_q;

    assign WR_RDY  = wr_rdy_q;
    assign wr_xfer = WR_VALID && wr_rdy_q;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_nxt;
    logic             miss_p1_q, miss_p2_q;
    logic             scan_drop;

    assign starve    = (state_q == PEND) && (wait_cnt_q == CNT_W'(WAIT_LIMIT));
    assign scan_drop = SCAN_REQ && wr_gnt;

    always_comb begin
        wait_cnt_nxt = wait_cnt_q;
        if (wr_gnt) begin
            wait_cnt_nxt = '0;
        end else if (state_q == PEND && wait_cnt_q != CNT_W'(WAIT_LIMIT)) begin
            wait_cnt_nxt = wait_cnt_q + CNT_W'(1);
        end
    end

    // The dropped request's miss flag travels the same 3-stage path as real read data,
    // so the consumer sees exactly one of RVALID/MISS in that slot.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wait_cnt_q <= '0;
            miss_p1_q  <= 1'b0;
            miss_p2_q  <= 1'b0;
            SCAN_MISS  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_nxt;
            miss_p1_q  <= scan_drop;
            miss_p2_q  <= miss_p1_q;
            SCAN_MISS  <= miss_p2_q;
        end
    end
`else
    logic unused_wait_limit;

    assign unused_wait_limit = (WAIT_LIMIT != 0);
    assign starve            = 1'b0;
    assign SCAN_MISS         = 1'b0;
`endif

    // Grant decision and next state. A held write only goes when scan is idle,
    // unless the starvation guard forces it through.
    always_comb begin
        state_nxt = state_q;
        wr_gnt    = 1'b0;
        scan_gnt  = 1'b0;
        if (state_q == PEND && (!SCAN_REQ || starve)) begin
            wr_gnt = 1'b1;
        end
        scan_gnt = SCAN_REQ && !wr_gnt;
        case (state_q)
            IDLE: if (wr_xfer) state_nxt = PEND;
            PEND: if (wr_gnt)  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_rdy_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            MEM_EN      <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            SCAN_RVALID <= 1'b0;
            SCAN_RDATA  <= '0;
        end else begin
            // Ready mirrors the state being entered, so it drops right after a
            // transfer and rises together with the write grant.
            wr_rdy_q <= (state_nxt == IDLE);
            if (wr_xfer) begin
                hold_addr_q <= WR_ADDR;
                hold_data_q <= WR_DATA;
            end

            MEM_EN <= scan_gnt || wr_gnt;
            MEM_WE <= wr_gnt;
            if (wr_gnt) begin
                MEM_ADDR  <= hold_addr_q;
                MEM_WDATA <= hold_data_q;
            end else if (scan_gnt) begin
                MEM_ADDR <= SCAN_ADDR;
            end

            rd_p1_q     <= scan_gnt;
            rd_p2_q     <= rd_p1_q;
            SCAN_RVALID <= rd_p2_q;
            if (rd_p2_q) begin
                SCAN_RDATA <= MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: behavioural memory, cycle-indexed expectation model and directed scenarios.
module tb_vga_mem_arbiter;
    localparam int AW = 17;
    localparam int DW = 12;
    localparam int WL = 64;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          SCAN_REQ;
    logic [AW-1:0] SCAN_ADDR;
    logic          SCAN_RVALID;
    logic [DW-1:0] SCAN_RDATA;
    logic          SCAN_MISS;
    logic          WR_VALID;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          WR_RDY;
    logic          MEM_EN;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;

    always #5 CLK = ~CLK;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_LIMIT(WL)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SCAN_REQ(SCAN_REQ), .SCAN_ADDR(SCAN_ADDR),
        .SCAN_RVALID(SCAN_RVALID), .SCAN_RDATA(SCAN_RDATA), .SCAN_MISS(SCAN_MISS),
        .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_RDY(WR_RDY),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_on   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) ^ 12'h5A5;
    endfunction

    // Single-port memory the DUT talks to: read data one cycle after a read enable.
    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] gold [0:(1<<AW)-1];

    always @(posedge CLK) begin
        if (MEM_EN === 1'b1) begin
            if (MEM_WE === 1'b1) mem[MEM_ADDR] <= MEM_WDATA;
            else                 MEM_RDATA     <= mem[MEM_ADDR];
        end
    end

    // Expectation model: each edge resolves who owns the memory slot of the next
    // cycle, applies writes to a golden image in grant order, and schedules read
    // results 3 cycles out in a small timetable.
    bit            m_pend, m_rdy;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_wait;
    int            m_xfers = 0;
    logic          e_en, e_we, e_rdy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            r_rv   [8];
    bit            r_miss [8];
    logic [DW-1:0] r_rd   [8];

    always @(posedge CLK) begin : model
        bit gw, gs, starve;
        int k;
        k = (cyc + 3) % 8;
        if (RST_N !== 1'b1) begin
            m_pend = 0; m_rdy = 0; m_wait = 0;
            e_en = 0; e_we = 0; e_rdy = 0; e_addr = '0; e_wdata = '0;
            for (int i = 0; i < 8; i++) begin r_rv[i] = 0; r_miss[i] = 0; end
        end else begin
            starve = 0;
`ifdef STARVE_GUARD_EN
            starve = m_pend && (m_wait == WL);
`endif
            gw = m_pend && (!SCAN_REQ || starve);
            gs = SCAN_REQ && !gw;
            e_en = gw || gs;
            e_we = gw;
            if (gw) begin
                e_addr = m_waddr; e_wdata = m_wdata; gold[m_waddr] = m_wdata;
            end else if (gs) begin
                e_addr = SCAN_ADDR;
            end
            if (gs) begin r_rv[k] = 1; r_rd[k] = gold[SCAN_ADDR]; end
            if (SCAN_REQ && gw) r_miss[k] = 1;
            if (gw) m_wait = 0;
            else if (m_pend && m_wait < WL) m_wait++;
            if (WR_VALID && m_rdy) begin
                m_pend = 1; m_waddr = WR_ADDR; m_wdata = WR_DATA; m_xfers++;
            end else if (gw) begin
                m_pend = 0;
            end
            m_rdy = !m_pend;
            e_rdy = m_rdy;
        end
        cyc++;
        chk_on = 1;
    end

    always @(negedge CLK) begin : compare
        int k;
        if (chk_on) begin
            k = cyc % 8;
            chk("mem_en",    32'(MEM_EN),      32'(e_en));
            chk("mem_we",    32'(MEM_WE),      32'(e_we));
            chk("mem_addr",  32'(MEM_ADDR),    32'(e_addr));
            chk("mem_wdata", 32'(MEM_WDATA),   32'(e_wdata));
            chk("wr_rdy",    32'(WR_RDY),      32'(e_rdy));
            chk("rvalid",    32'(SCAN_RVALID), 32'(r_rv[k]));
            chk("miss",      32'(SCAN_MISS),   32'(r_miss[k]));
            if (r_rv[k]) chk("rdata", 32'(SCAN_RDATA), 32'(r_rd[k]));
            r_rv[k]   = 0;
            r_miss[k] = 0;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int we_n, rv_n, miss_n, xf_n, we_at, miss_at;
        RST_N = 1'b0; SCAN_REQ = 1'b0; SCAN_ADDR = '0;
        WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]  = init_val(i);
            gold[i] = init_val(i);
        end

        // Reset state
        repeat (3) tick;
        chk("rst_wr_rdy", 32'(WR_RDY), 32'd0);
        chk("rst_mem_en", 32'(MEM_EN), 32'd0);
        chk("rst_mem_we", 32'(MEM_WE), 32'd0);
        chk("rst_rvalid", 32'(SCAN_RVALID), 32'd0);
        chk("rst_miss", 32'(SCAN_MISS), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_rdata", 32'(SCAN_RDATA), 32'd0);
        RST_N = 1'b1;
        tick;
        chk("rdy_after_release", 32'(WR_RDY), 32'd1);

        // Single scan read of 0x00010: port at t+1, data at t+3
        SCAN_REQ = 1'b1; SCAN_ADDR = 17'h00010;
        tick;
        SCAN_REQ = 1'b0;
        chk("scan_en", 32'(MEM_EN), 32'd1);
        chk("scan_we", 32'(MEM_WE), 32'd0);
        chk("scan_addr", 32'(MEM_ADDR), 32'h10);
        tick;
        chk("scan_rvalid_early", 32'(SCAN_RVALID), 32'd0);
        tick;
        chk("scan_rvalid", 32'(SCAN_RVALID), 32'd1);
        chk("scan_rdata", 32'(SCAN_RDATA), 32'h5B5);

        // Idle write of 0xF00 to 0x1FFFF
        WR_VALID = 1'b1; WR_ADDR = 17'h1FFFF; WR_DATA = 12'hF00;
        chk("wr_rdy_at_xfer", 32'(WR_RDY), 32'd1);
        tick;
        WR_VALID = 1'b0;
        chk("wr_rdy_c1", 32'(WR_RDY), 32'd0);
        chk("wr_we_c1", 32'(MEM_WE), 32'd0);
        tick;
        chk("wr_we_c2", 32'(MEM_WE), 32'd1);
        chk("wr_en_c2", 32'(MEM_EN), 32'd1);
        chk("wr_addr_c2", 32'(MEM_ADDR), 32'h1FFFF);
        chk("wr_data_c2", 32'(MEM_WDATA), 32'hF00);
        chk("wr_rdy_c2", 32'(WR_RDY), 32'd1);
        SCAN_REQ = 1'b1; SCAN_ADDR = 17'h1FFFF;
        tick;
        SCAN_REQ = 1'b0;
        repeat (2) tick;
        chk("readback_rvalid", 32'(SCAN_RVALID), 32'd1);
        chk("readback_rdata", 32'(SCAN_RDATA), 32'hF00);
        tick;

`ifndef STARVE_GUARD_EN
        // Contention: write held behind 640 cycles of scan
        we_n = 0; rv_n = 0;
        WR_VALID = 1'b1; WR_ADDR = 17'h00123; WR_DATA = 12'hABC;
        for (int i = 0; i < 640; i++) begin
            SCAN_REQ = 1'b1; SCAN_ADDR = AW'(i);
            if (MEM_WE) we_n++;
            if (SCAN_RVALID) rv_n++;
            tick;
            WR_VALID = 1'b0;
        end
        SCAN_REQ = 1'b0;
        if (MEM_WE) we_n++;
        if (SCAN_RVALID) rv_n++;
        tick;
        chk("contend_we_after_fall", 32'(MEM_WE), 32'd1);
        chk("contend_we_addr", 32'(MEM_ADDR), 32'h123);
        for (int j = 0; j < 5; j++) begin
            if (SCAN_RVALID) rv_n++;
            tick;
        end
        chk("contend_no_we", 32'(we_n), 32'd0);
        chk("contend_rvalid_cnt", 32'(rv_n), 32'd640);
`else
        // Starvation guard: one forced write after 64 blocked cycles, one miss 2 cycles later
        we_n = 0; rv_n = 0; miss_n = 0; we_at = -1; miss_at = -1;
        WR_VALID = 1'b1; WR_ADDR = 17'h00456; WR_DATA = 12'h321;
        for (int i = 0; i < 200; i++) begin
            SCAN_REQ = 1'b1; SCAN_ADDR = AW'(i + 64);
            if (MEM_WE) begin we_n++; we_at = i; end
            if (SCAN_MISS) begin miss_n++; miss_at = i; end
            if (SCAN_RVALID) rv_n++;
            tick;
            WR_VALID = 1'b0;
        end
        SCAN_REQ = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (MEM_WE) we_n++;
            if (SCAN_MISS) miss_n++;
            if (SCAN_RVALID) rv_n++;
            tick;
        end
        chk("starve_we_cnt", 32'(we_n), 32'd1);
        chk("starve_we_at", 32'(we_at), 32'd66);
        chk("starve_miss_cnt", 32'(miss_n), 32'd1);
        chk("starve_miss_at", 32'(miss_at), 32'd68);
        chk("starve_rvalid_cnt", 32'(rv_n), 32'd199);
`endif

        // Reset while a write is held and two reads are in flight
        we_n = 0; rv_n = 0;
        WR_VALID = 1'b1; WR_ADDR = 17'h00777; WR_DATA = 12'h0AA;
        SCAN_REQ = 1'b1; SCAN_ADDR = 17'h5;
        tick;
        WR_VALID = 1'b0; SCAN_ADDR = 17'h6;
        tick;
        SCAN_REQ = 1'b0; RST_N = 1'b0;
        if (MEM_WE) we_n++;
        if (SCAN_RVALID) rv_n++;
        tick;
        RST_N = 1'b1;
        chk("midrst_rdy_in_reset", 32'(WR_RDY), 32'd0);
        for (int j = 0; j < 7; j++) begin
            if (MEM_WE) we_n++;
            if (SCAN_RVALID) rv_n++;
            if (j == 1) chk("midrst_rdy_after", 32'(WR_RDY), 32'd1);
            tick;
        end
        chk("midrst_no_we", 32'(we_n), 32'd0);
        chk("midrst_no_rvalid", 32'(rv_n), 32'd0);

        // Random mix over a small address window to force read-after-write hits
        we_n = 0; xf_n = 0;
        for (int i = 0; i < 10000; i++) begin
            SCAN_REQ  = ($urandom_range(0, 99) < 70);
            SCAN_ADDR = AW'($urandom_range(0, 63));
            WR_VALID  = ($urandom_range(0, 99) < 40);
            WR_ADDR   = AW'($urandom_range(0, 63));
            WR_DATA   = DW'($urandom);
            if (WR_VALID && WR_RDY) xf_n++;
            if (MEM_WE) we_n++;
            tick;
        end
        SCAN_REQ = 1'b0; WR_VALID = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (MEM_WE) we_n++;
            tick;
        end
        chk("rand_write_count", 32'(we_n), 32'(xf_n));
        chk("rand_model_xfers", 32'(m_xfers), 32'(xf_n + 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 17, memory address width; DATA_W, default 12, pixel word width (4:4:4 RGB); WAIT_LIMIT, default 64, write-starvation limit in cycles.
REQ-002 CLK  input  1  the single clock (pixel-memory domain); all logic SHALL be clocked on its rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 SCAN_REQ  input  1  scan-out read request, one word per asserted cycle, no back-pressure.
REQ-005 SCAN_ADDR  input  ADDR_W  scan-out read address, qualified by SCAN_REQ.
REQ-006 SCAN_RVALID  output  1  read data valid pulse.
REQ-007 SCAN_RDATA  output  DATA_W  read data, qualified by SCAN_RVALID.
REQ-008 SCAN_MISS  output  1  pulse marking a scan request that was dropped.
REQ-009 WR_VALID  input  1  writer request.
REQ-010 WR_ADDR  input  ADDR_W  write address.
REQ-011 WR_DATA  input  DATA_W  write data.
REQ-012 WR_RDY  output  1  writer may transfer; a transfer occurs when WR_VALID and WR_RDY are both high.
REQ-013 MEM_EN, MEM_WE  output  1 each  single-port memory enable and write enable.
REQ-014 MEM_ADDR  output  ADDR_W  memory address.
REQ-015 MEM_WDATA  output  DATA_W  memory write data.
REQ-016 MEM_RDATA  input  DATA_W  memory read data, valid 1 cycle after a read enable.

Function
REQ-017 The block SHALL use a 1-entry write holding register with states IDLE (empty) and PEND (holding a write).
REQ-018 WR_RDY SHALL be registered and high only in IDLE.
- IDLE->PEND on a WR_VALID and WR_RDY transfer.
- WR_RDY SHALL drop the cycle after the transfer.
REQ-019 The grant decision SHALL be made in cycle t from SCAN_REQ and the state. All memory port outputs SHALL be registered and reflect that decision in cycle t+1.
REQ-020 Scan grant: if SCAN_REQ is high in cycle t and not preempted (REQ-024), the block SHALL drive MEM_EN=1, MEM_WE=0, MEM_ADDR=SCAN_ADDR at t+1.
REQ-021 The read data SHALL appear with SCAN_RVALID=1 and SCAN_RDATA=MEM_RDATA (registered) at t+3, giving a fixed latency of 3 cycles with no bubbles for back-to-back requests.
REQ-022 Write grant: in PEND with SCAN_REQ low in cycle t, the block SHALL drive MEM_EN=1, MEM_WE=1 and the held address/data at t+1. The state SHALL return to IDLE at t+1, and WR_RDY SHALL be high at t+1.
REQ-023 With no grant, MEM_EN and MEM_WE SHALL be 0. MEM_ADDR and MEM_WDATA SHALL hold their last values.
REQ-024 Only with STARVE_GUARD_EN (REQ-029): when the wait counter equals WAIT_LIMIT in cycle t, the write SHALL win even if SCAN_REQ is high.
- The dropped scan request SHALL give SCAN_MISS=1 and SCAN_RVALID=0 at t+3.
- SCAN_RDATA is don't-care in that cycle.
REQ-025 SCAN_RVALID and SCAN_MISS SHALL never be high in the same cycle. At most one memory access SHALL occur per cycle.
REQ-026 A write transfer SHALL never be lost or duplicated. The write data SHALL equal the WR_DATA sampled at transfer.

Reset
REQ-027 While RST_N is low at a clock edge, the block SHALL force:
- state to IDLE;
- WR_RDY, MEM_EN, MEM_WE, SCAN_RVALID and SCAN_MISS to 0;
- MEM_ADDR, MEM_WDATA and SCAN_RDATA to 0;
- the wait counter to 0;
- all read-pipeline valid bits to 0.
REQ-028 WR_RDY SHALL be 1 on the first edge after RST_N goes high.
- A reset asserted mid-operation SHALL discard any held write and any in-flight reads.
- No SCAN_RVALID or SCAN_MISS pulse SHALL appear afterwards for requests made before reset.

Configuration
REQ-029 The macro STARVE_GUARD_EN SHALL control the starvation guard.
- When defined: a wait counter (width clog2(WAIT_LIMIT+1)) SHALL increment each PEND cycle in which the write is not granted, saturate at WAIT_LIMIT, and clear on write grant.
- When undefined: scan SHALL always win, the counter SHALL be absent, and SCAN_MISS SHALL be constant 0.

Verification
REQ-030 Single scan: SCAN_REQ=1 with SCAN_ADDR=0x00010 at cycle 5 -> MEM_EN=1, MEM_WE=0, MEM_ADDR=0x00010 at cycle 6; SCAN_RVALID=1 with the memory word at cycle 8.
REQ-031 Idle write: WR_VALID=1, WR_ADDR=0x1FFFF, WR_DATA=0xF00, no scan -> transfer at cycle c; MEM_WE=1 at cycle c+2; WR_RDY low at c+1 and high at c+2.
REQ-032 Contention: write held and SCAN_REQ high for 640 cycles with the guard off -> no MEM_WE pulse during those cycles; the write issues 1 cycle after SCAN_REQ falls; 640 SCAN_RVALID pulses.
REQ-033 Guard on, WAIT_LIMIT=64, continuous SCAN_REQ -> exactly one MEM_WE pulse after 64 blocked cycles; exactly one SCAN_MISS pulse 2 cycles later; 1 RVALID lost per held write.
REQ-034 Reset mid-operation: RST_N low for 1 cycle while a write is held and 2 reads are in flight -> no MEM_WE pulse, no RVALID pulse, WR_RDY=1 one cycle after release.
REQ-035 Random mix of 10k scan and write requests checked against a memory model -> read data matches the model, and the write count equals the transfer count.
